mem_port_arbiter: RTL

Shares one single-ported backing memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage core. Data accesses take fixed priority, and a starvation counter guarantees fetch progress. Each requester sees a req/valid handshake with a one-cycle valid pulse. A cycle timeout prevents a dead memory from hanging the pipeline.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the fetch stage and the memory
// stage. Data accesses have fixed priority. A starvation counter forces a
// fetch grant after STARVE_LIMIT back-to-back data grants. A BUSY-cycle
// timeout aborts accesses that the memory never acknowledges.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // fetch requester
  input  logic              ireq_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic              ivalid_o,
  output logic [DATA_W-1:0] irdata_o,
  // data requester
  input  logic              dreq_i,
  input  logic              dwe_i,
  input  logic [ADDR_W-1:0] daddr_i,
  input  logic [DATA_W-1:0] dwdata_i,
  output logic              dvalid_o,
  output logic [DATA_W-1:0] drdata_o,
  output logic              err_o,
  // memory port
  output logic              mreq_o,
  output logic              mwe_o,
  output logic [ADDR_W-1:0] maddr_o,
  output logic [DATA_W-1:0] mwdata_o,
  input  logic [DATA_W-1:0] mrdata_i,
  input  logic              mack_i
);

  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIMIT);
  localparam logic [TCNT_W-1:0] TMO_LAST   = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [SCNT_W-1:0]   starve_q;
  logic [SCNT_W-1:0]   starve_d;
  logic [TCNT_W-1:0]   tmo_q;
  logic                gnt_data_q;   // 1 = current access belongs to the data port
  logic                fetch_win_d;

  logic                ivalid_q;
  logic                dvalid_q;
  logic                err_q;
  logic [DATA_W-1:0]   irdata_q;
  logic [DATA_W-1:0]   drdata_q;
  logic                mreq_q;
  logic                mwe_q;
  logic [ADDR_W-1:0]   maddr_q;
  logic [DATA_W-1:0]   mwdata_q;

  // Saturating increment for the starvation counter.
  function automatic logic [SCNT_W-1:0] sat_inc(input logic [SCNT_W-1:0] v);
    if (v == STARVE_MAX) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Arbitration decision and starvation counter next value (only moves in IDLE).
  always_comb begin
    fetch_win_d = ireq_i && (!dreq_i || (starve_q == STARVE_MAX));
    starve_d    = starve_q;
    if (state_q == IDLE) begin
      if (!ireq_i || fetch_win_d) begin
        starve_d = '0;
      end else if (dreq_i) begin
        starve_d = sat_inc(starve_q);
      end
    end
  end

  // Access FSM; every output is a register written here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      tmo_q      <= '0;
      gnt_data_q <= 1'b0;
      ivalid_q   <= 1'b0;
      dvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      irdata_q   <= '0;
      drdata_q   <= '0;
      mreq_q     <= 1'b0;
      mwe_q      <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
    end else begin
      // valid and error are single-cycle pulses
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      starve_q <= starve_d;
      unique case (state_q)
        IDLE: begin
          if (ireq_i || dreq_i) begin
            gnt_data_q <= !fetch_win_d;
            mreq_q     <= 1'b1;
            mwe_q      <= fetch_win_d ? 1'b0 : dwe_i;
            maddr_q    <= fetch_win_d ? iaddr_i : daddr_i;
            mwdata_q   <= fetch_win_d ? '0 : dwdata_i;
            tmo_q      <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          // an acknowledge on the timeout cycle still completes normally
          if (mack_i) begin
            mreq_q <= 1'b0;
            if (!mwe_q) begin
              if (gnt_data_q) begin
                drdata_q <= mrdata_i;
              end else begin
                irdata_q <= mrdata_i;
              end
            end
            ivalid_q <= !gnt_data_q;
            dvalid_q <= gnt_data_q;
            state_q  <= RESP;
          end else if (tmo_q == TMO_LAST) begin
            mreq_q <= 1'b0;
            if (gnt_data_q) begin
              drdata_q <= '0;
            end else begin
              irdata_q <= '0;
            end
            ivalid_q <= !gnt_data_q;
            dvalid_q <= gnt_data_q;
            err_q    <= 1'b1;
            state_q  <= RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP: begin
          // the response pulse is on the outputs this cycle; requests wait
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ivalid_o = ivalid_q;
  assign dvalid_o = dvalid_q;
  assign err_o    = err_q;
  assign irdata_o = irdata_q;
  assign drdata_o = drdata_q;
  assign mreq_o   = mreq_q;
  assign mwe_o    = mwe_q;
  assign maddr_o  = maddr_q;
  assign mwdata_o = mwdata_q;

endmodule
